btn_event_ctrl: RTL and testbench
=================================

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 Parameter N_BTN, default 4: number of buttons, 2..8.
REQ-002 Parameter LOCK_CYCLES, default 1000000: per-button lockout length in clk cycles, at least 2 (20 ms at 50 MHz).
REQ-003 clk  in  1  single clock, all state on posedge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 btn  in  N_BTN  raw button levels.
REQ-006 evt_ready  in  1  consumer accepts head event.
REQ-007 ovf_clr  in  1  clears ovf.
REQ-008 btn_state  out  N_BTN  debounced levels.
REQ-009 evt_valid  out  1  event FIFO non-empty.
REQ-010 evt_id  out  clog2(N_BTN)  button index of head event.
REQ-011 evt_press  out  1  head event polarity: 1 = press (0->1), 0 = release.
REQ-012 ovf  out  1  sticky flag: an event was dropped.

Function
REQ-013 Each button SHALL have its own FSM with states IDLE and LOCK, plus its own counter of width clog2(LOCK_CYCLES).
REQ-014 Request: a button in IDLE whose sampled level differs from btn_state[i] SHALL raise a commit request.
REQ-015 Arbitration: at most one request SHALL be granted per cycle, round-robin starting at (last granted + 1) mod N_BTN.
REQ-016 Ungranted requests SHALL persist and be re-arbitrated on the next cycle.
REQ-017 Grant at edge k SHALL:
  - toggle btn_state[i];
  - move button i to LOCK and load its counter with LOCK_CYCLES-1;
  - write {i, new level} into the FIFO.
  btn_state and evt_valid SHALL be visible after edge k.
REQ-018 In LOCK the counter SHALL decrement each cycle and btn[i] SHALL be ignored.
REQ-019 On the counter-zero cycle the button SHALL return to IDLE; it becomes eligible for a request on the next cycle. A level that still differs then SHALL raise a new request.
REQ-020 The event FIFO SHALL be 4 entries deep and show-ahead.
REQ-021 evt_id and evt_press SHALL reflect the head entry whenever evt_valid=1.
REQ-022 Pop SHALL occur when evt_valid and evt_ready are both 1 at an edge.
REQ-023 Push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge.
REQ-024 Push when full without a pop: the event SHALL be dropped, the btn_state update SHALL still occur, and ovf SHALL be set.
REQ-025 ovf SHALL be cleared by ovf_clr; set SHALL win when set and clear coincide.
REQ-026 FIFO pointers SHALL wrap modulo 4; the count SHALL never exceed 4 or go below 0.

Reset
REQ-027 rst_n low SHALL immediately force:
  - btn_state = 0, all FSMs in IDLE, all counters 0;
  - FIFO empty, evt_valid = 0, ovf = 0;
  - round-robin last-granted pointer = N_BTN-1, so button 0 has first priority.
REQ-028 Reset asserted mid-lockout or with a non-empty FIFO SHALL discard all pending state; nothing SHALL be retained.
REQ-029 After rst_n deasserts, any button held high SHALL generate a press event through normal arbitration.

Configuration
REQ-030 Macro BTN_SYNC_EN.
  - Defined: btn SHALL pass through a 2-flop synchronizer reset to 0, adding exactly 2 cycles of request latency.
  - Undefined: btn SHALL be sampled directly.

Verification (bench: N_BTN=4, LOCK_CYCLES=8, BTN_SYNC_EN undefined, evt_ready=1 unless stated)
REQ-031 Single press: btn=0001 at edge 10 -> btn_state=0001 and evt_valid=1, id=0, press=1 after edge 10. Bouncing btn[0] over edges 11..17 is ignored; btn[0] low at edge 18 -> release event.
REQ-032 Simultaneous presses: btn 0000->1111 in one cycle -> grants at four consecutive edges in order 0,1,2,3, each with press=1.
REQ-033 Round-robin: last grant=2, then btn[0] and btn[3] request together -> button 3 granted first, button 0 on the next edge.
REQ-034 Overflow: evt_ready=0, five press/release commits -> after the 5th, the FIFO holds 4 entries, ovf=1, and btn_state is current. ovf_clr then clears ovf; ovf_clr together with a 6th drop -> ovf stays 1.
REQ-035 Full with pop: FIFO full, evt_ready=1 on the same edge as a commit -> event accepted, count stays 4, ovf=0.
REQ-036 Reset mid-operation: rst_n low 3 cycles into a lockout with 2 queued events -> outputs 0 immediately. btn[1] held high at release -> press event id=1 on the first edge after release.

Source files
------------

// File: rtl/btn_event_if.sv
// Button event controller port bundle: raw buttons in, debounced levels and
// a show-ahead event stream out. Driver side uses master, controller uses slave.
interface btn_event_if #(
  parameter int N_BTN = 4
);
  localparam int ID_W = $clog2(N_BTN);

  logic [N_BTN-1:0] btn;
  logic             evt_ready;
  logic             ovf_clr;
  logic [N_BTN-1:0] btn_state;
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;
  logic             evt_press;
  logic             ovf;

  modport master (
    output btn, evt_ready, ovf_clr,
    input  btn_state, evt_valid, evt_id, evt_press, ovf
  );

  modport slave (
    input  btn, evt_ready, ovf_clr,
    output btn_state, evt_valid, evt_id, evt_press, ovf
  );
endinterface

// File: rtl/btn_event_ctrl.sv
// Per-button lockout debouncer with round-robin commit arbiter and a 4-deep
// show-ahead event FIFO. Define BTN_SYNC_EN to add a 2-flop input synchronizer.
module btn_event_ctrl #(
  parameter int N_BTN       = 4,
  parameter int LOCK_CYCLES = 1000000
) (
  input logic       clk,
  input logic       rst_n,
  btn_event_if.slave bus
);
  localparam int ID_W  = $clog2(N_BTN);
  localparam int CNT_W = $clog2(LOCK_CYCLES);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [N_BTN-1:0] btn_smp_s;
  logic [N_BTN-1:0] req_s;
  logic [N_BTN-1:0] btn_state_r;
  logic [0:0]       state_r [N_BTN];
  logic [CNT_W-1:0] cnt_r   [N_BTN];
  logic [ID_W-1:0]  last_r;
  logic [ID_W-1:0]  cand_s;
  logic             gnt_vld_s;
  logic [ID_W-1:0]  gnt_idx_s;

  logic [ID_W:0]    mem_r [4];
  logic [1:0]       rd_ptr_r, wr_ptr_r, rd_nxt_s;
  logic [2:0]       count_r, count_nxt_s;
  logic             evt_valid_r, ovf_r;
  logic [ID_W:0]    head_r, head_nxt_s, new_entry_s;
  logic             pop_s, push_s, drop_s, full_s;

`ifdef BTN_SYNC_EN
  logic [N_BTN-1:0] sync1_r, sync2_r;

  // Two-stage synchronizer for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= bus.btn;
      sync2_r <= sync1_r;
    end
  end
  assign btn_smp_s = sync2_r;
`else
  assign btn_smp_s = bus.btn;
`endif

  // A button asks to commit only while idle and its level disagrees with btn_state
  always_comb begin
    req_s = '0;
    for (int i = 0; i < N_BTN; i++) begin
      req_s[i] = (state_r[i] == ST_IDLE) && (btn_smp_s[i] != btn_state_r[i]);
    end
  end

  // Round-robin search starting one past the last granted button
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    cand_s    = '0;
    for (int off = 1; off <= N_BTN; off++) begin
      cand_s = ID_W'((int'(last_r) + off) % N_BTN);
      if (!gnt_vld_s && req_s[cand_s]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = cand_s;
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
  end

  // Per-button lockout FSM; the button leaves LOCK as its counter reaches zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_r[i] <= ST_IDLE;
        cnt_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (gnt_vld_s && (gnt_idx_s == ID_W'(i))) begin
          state_r[i] <= ST_LOCK;
          cnt_r[i]   <= CNT_W'(LOCK_CYCLES - 1);
        end else if (state_r[i] == ST_LOCK) begin
          state_r[i] <= (cnt_r[i] == CNT_W'(1)) ? ST_IDLE : ST_LOCK;
          cnt_r[i]   <= cnt_r[i] - CNT_W'(1);
        end else begin
          state_r[i] <= ST_IDLE;
          cnt_r[i]   <= '0;
        end
      end
    end
  end

  // Debounced levels and round-robin pointer follow each grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_state_r <= '0;
      last_r      <= ID_W'(N_BTN - 1);
    end else if (gnt_vld_s) begin
      btn_state_r[gnt_idx_s] <= ~btn_state_r[gnt_idx_s];
      last_r                 <= gnt_idx_s;
    end else begin
      btn_state_r <= btn_state_r;
      last_r      <= last_r;
    end
  end

  // FIFO next state; the head is precomputed so evt_id/evt_press come from flops
  always_comb begin
    pop_s       = evt_valid_r & bus.evt_ready;
    full_s      = (count_r == 3'd4);
    push_s      = gnt_vld_s & (~full_s | pop_s);
    drop_s      = gnt_vld_s & full_s & ~pop_s;
    new_entry_s = {gnt_idx_s, ~btn_state_r[gnt_idx_s]};
    rd_nxt_s    = pop_s ? (rd_ptr_r + 2'd1) : rd_ptr_r;
    count_nxt_s = count_r + {2'b00, push_s} - {2'b00, pop_s};
    if (count_nxt_s == 3'd0) begin
      head_nxt_s = '0;
    end else if (push_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = new_entry_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // FIFO storage, pointers and sticky overflow (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) begin
        mem_r[j] <= '0;
      end
      rd_ptr_r    <= 2'd0;
      wr_ptr_r    <= 2'd0;
      count_r     <= 3'd0;
      evt_valid_r <= 1'b0;
      head_r      <= '0;
      ovf_r       <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= new_entry_s;
        wr_ptr_r        <= wr_ptr_r + 2'd1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_nxt_s;
      count_r     <= count_nxt_s;
      evt_valid_r <= (count_nxt_s != 3'd0);
      head_r      <= head_nxt_s;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign bus.btn_state = btn_state_r;
  assign bus.evt_valid = evt_valid_r;
  assign bus.evt_id    = head_r[ID_W:1];
  assign bus.evt_press = head_r[0];
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl (N_BTN=4, LOCK_CYCLES=8): directed scenarios plus
// randomized traffic against a time-stamp based reference model.
module tb_btn_event_ctrl;
  localparam int NB   = 4;
  localparam int LOCK = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;

  btn_event_if #(.N_BTN(NB)) bif ();

  btn_event_ctrl #(.N_BTN(NB), .LOCK_CYCLES(LOCK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: committed levels, earliest edge each button may commit again,
  // last winner, event queue and sticky overflow.
  int         cyc = 0;
  logic [3:0] m_state;
  int         m_lock [NB];
  int         m_last;
  logic [2:0] m_q [$];
  logic       m_ovf;

  task automatic model_reset();
    m_state = 4'b0000;
    for (int i = 0; i < NB; i++) m_lock[i] = 0;
    m_last = NB - 1;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  // Advance model and DUT by one edge using the inputs currently applied
  task automatic tick();
    int  g;
    bit  pop;
    bit  drop;
    cyc++;
    g = -1;
    drop = 1'b0;
    for (int off = 1; off <= NB; off++) begin
      int c;
      c = (m_last + off) % NB;
      if (g < 0 && cyc >= m_lock[c] && bif.btn[c] != m_state[c]) g = c;
    end
    pop = (m_q.size() > 0) && bif.evt_ready;
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_state[g] = ~m_state[g];
      m_lock[g]  = cyc + LOCK;
      m_last     = g;
      if (m_q.size() < 4) m_q.push_back({g[1:0], m_state[g]});
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (bif.ovf_clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bif.btn = 4'b0000;
    bif.evt_ready = 1'b1;
    bif.ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bif.btn = 4'b1010;
    bif.evt_ready = 1'b1;
    bif.ovf_clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bif.btn_state !== 4'b0000) begin errors++; $display("FAIL rst_state: got %b expected 0000", bif.btn_state); end
    checks++; if (bif.evt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bif.evt_valid); end
    checks++; if (bif.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bif.ovf); end
    @(posedge clk);
    #1;
    do_reset();
  endtask

  task automatic test_single_press();
    do_reset();
    repeat (9) tick();
    bif.btn = 4'b0001;
    tick();
    checks++; if (bif.btn_state !== 4'b0001) begin errors++; $display("FAIL sp_state: got %b expected 0001", bif.btn_state); end
    checks++; if ({bif.evt_valid, bif.evt_id, bif.evt_press} !== 4'b1001) begin errors++; $display("FAIL sp_event: got v%b id%0d p%b expected v1 id0 p1", bif.evt_valid, bif.evt_id, bif.evt_press); end
    for (int k = 0; k < 7; k++) begin
      bif.btn = {3'b000, 1'($urandom_range(1, 0))};
      tick();
      checks++; if (bif.btn_state !== 4'b0001 || bif.evt_valid !== 1'b0) begin errors++; $display("FAIL sp_bounce%0d: got state %b valid %b expected 0001 0", k, bif.btn_state, bif.evt_valid); end
    end
    bif.btn = 4'b0000;
    tick();
    checks++; if (bif.btn_state !== 4'b0000) begin errors++; $display("FAIL sp_rel_state: got %b expected 0000", bif.btn_state); end
    checks++; if ({bif.evt_valid, bif.evt_id, bif.evt_press} !== 4'b1000) begin errors++; $display("FAIL sp_release: got v%b id%0d p%b expected v1 id0 p0", bif.evt_valid, bif.evt_id, bif.evt_press); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_state;
    do_reset();
    bif.btn = 4'b1111;
    exp_state = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_state[k] = 1'b1;
      checks++; if ({bif.evt_valid, bif.evt_id, bif.evt_press} !== {1'b1, 2'(k), 1'b1} || bif.btn_state !== exp_state) begin
        errors++; $display("FAIL sim_grant%0d: got v%b id%0d p%b state %b expected v1 id%0d p1 state %b", k, bif.evt_valid, bif.evt_id, bif.evt_press, bif.btn_state, k, exp_state);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bif.btn = 4'b0100;
    tick();
    checks++; if (bif.evt_id !== 2'd2) begin errors++; $display("FAIL rr_setup: got id%0d expected id2", bif.evt_id); end
    bif.btn = 4'b1101;
    tick();
    checks++; if ({bif.evt_valid, bif.evt_id, bif.evt_press} !== 4'b1111) begin errors++; $display("FAIL rr_first: got v%b id%0d p%b expected v1 id3 p1", bif.evt_valid, bif.evt_id, bif.evt_press); end
    tick();
    checks++; if ({bif.evt_valid, bif.evt_id, bif.evt_press} !== 4'b1001) begin errors++; $display("FAIL rr_second: got v%b id%0d p%b expected v1 id0 p1", bif.evt_valid, bif.evt_id, bif.evt_press); end
  endtask

  task automatic test_overflow();
    do_reset();
    bif.evt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bif.btn[k] = 1'b1;
      tick();
    end
    bif.btn = 4'b1110;
    repeat (5) tick();
    checks++; if (bif.ovf !== 1'b1 || bif.btn_state !== 4'b1110) begin errors++; $display("FAIL ovf_set: got ovf %b state %b expected 1 1110", bif.ovf, bif.btn_state); end
    checks++; if ({bif.evt_valid, bif.evt_id, bif.evt_press} !== 4'b1001) begin errors++; $display("FAIL ovf_head: got v%b id%0d p%b expected v1 id0 p1", bif.evt_valid, bif.evt_id, bif.evt_press); end
    bif.ovf_clr = 1'b1;
    tick();
    checks++; if (bif.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", bif.ovf); end
    bif.btn = 4'b1100;
    tick();
    checks++; if (bif.ovf !== 1'b1 || bif.btn_state !== 4'b1100) begin errors++; $display("FAIL ovf_set_wins: got ovf %b state %b expected 1 1100", bif.ovf, bif.btn_state); end
    bif.ovf_clr = 1'b0;
    bif.evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({bif.evt_valid, bif.evt_id, bif.evt_press} !== {1'b1, 2'(k), 1'b1}) begin errors++; $display("FAIL ovf_drain%0d: got v%b id%0d p%b expected v1 id%0d p1", k, bif.evt_valid, bif.evt_id, bif.evt_press, k); end
      tick();
    end
    checks++; if (bif.evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", bif.evt_valid); end
  endtask

  task automatic test_full_pop();
    do_reset();
    bif.evt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bif.btn[k] = 1'b1;
      tick();
    end
    bif.btn = 4'b1110;
    repeat (4) tick();
    bif.evt_ready = 1'b1;
    tick();
    checks++; if (bif.ovf !== 1'b0 || bif.btn_state !== 4'b1110) begin errors++; $display("FAIL fp_accept: got ovf %b state %b expected 0 1110", bif.ovf, bif.btn_state); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (m_q.size() == 0) begin
        if (bif.evt_valid !== 1'b0) begin errors++; $display("FAIL fp_drain%0d: got valid %b expected 0", k, bif.evt_valid); end
      end else if ({bif.evt_valid, bif.evt_id, bif.evt_press} !== {1'b1, m_q[0]}) begin
        errors++; $display("FAIL fp_drain%0d: got v%b id%0d p%b expected v1 id%0d p%b", k, bif.evt_valid, bif.evt_id, bif.evt_press, m_q[0][2:1], m_q[0][0]);
      end
      tick();
    end
    checks++; if (bif.evt_valid !== 1'b0) begin errors++; $display("FAIL fp_count: got valid %b expected 0 after four pops", bif.evt_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bif.evt_ready = 1'b0;
    bif.btn = 4'b0001;
    tick();
    bif.btn = 4'b0101;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({bif.btn_state, bif.evt_valid, bif.evt_id, bif.evt_press, bif.ovf} !== 9'd0) begin
      errors++; $display("FAIL rm_async: got state %b v%b id%0d p%b ovf %b expected all 0", bif.btn_state, bif.evt_valid, bif.evt_id, bif.evt_press, bif.ovf);
    end
    model_reset();
    bif.btn = 4'b0010;
    bif.evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if ({bif.evt_valid, bif.evt_id, bif.evt_press} !== 4'b1011 || bif.btn_state !== 4'b0010) begin
      errors++; $display("FAIL rm_press: got v%b id%0d p%b state %b expected v1 id1 p1 0010", bif.evt_valid, bif.evt_id, bif.evt_press, bif.btn_state);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(5, 0) == 0) bif.btn[b] = ~bif.btn[b];
      end
      bif.evt_ready = (n < 300) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
      bif.ovf_clr   = ($urandom_range(7, 0) == 0);
      tick();
      checks++;
      if (bif.btn_state !== m_state || bif.ovf !== m_ovf || bif.evt_valid !== (m_q.size() != 0)) begin
        errors++; $display("FAIL rnd_state@%0d: got state %b ovf %b v%b expected %b %b %b", n, bif.btn_state, bif.ovf, bif.evt_valid, m_state, m_ovf, m_q.size() != 0);
      end else if (m_q.size() != 0 && {bif.evt_id, bif.evt_press} !== m_q[0]) begin
        errors++; $display("FAIL rnd_head@%0d: got id%0d p%b expected id%0d p%b", n, bif.evt_id, bif.evt_press, m_q[0][2:1], m_q[0][0]);
      end
    end
  endtask

  initial begin
    bif.btn = 4'b0000;
    bif.evt_ready = 1'b1;
    bif.ovf_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_round_robin();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
